// File: rtl/data_mem_ctrl_if.sv
// Bundle between the load/store unit, the memory controller and the byte RAM.
// The master side is the LS unit plus the RAM; the slave side is the controller.
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  dataEn;
  logic                  LSRW;
  logic [ADDR_WIDTH-1:0] dataAddr;
  logic [2:0]            LSlen;
  logic [31:0]           Sdata;
  logic                  LSoutEn;
  logic [31:0]           Ldata;
  logic                  LSfree;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memRW;
  logic [7:0]            memWdata;
  logic [7:0]            memRdata;

  modport master (
    output dataEn, LSRW, dataAddr, LSlen, Sdata, memRdata,
    input  LSoutEn, Ldata, LSfree, memAddr, memRW, memWdata
  );

  modport slave (
    input  dataEn, LSRW, dataAddr, LSlen, Sdata, memRdata,
    output LSoutEn, Ldata, LSfree, memAddr, memRW, memWdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Serialises byte/half/word LS accesses onto a single-port byte RAM.
// The RAM read data lags the address by one cycle, so reads need one extra
// cycle to collect the final byte. All outputs are registered.
//
// state | meaning
// IDLE  | ready, RAM bus quiet, accepts dataEn
// XFER  | presenting byte addresses / collecting read bytes
// DONE  | one-cycle completion pulse on LSoutEn
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state, state_nxt;
  // idx counts bytes already presented; during a read, the byte on memRdata is idx-2
  logic [2:0]            idx, idx_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
  logic                  lat_rw, lat_rw_nxt;
  logic [2:0]            lat_n, lat_n_nxt;
  logic [31:0]           lat_sdata, lat_sdata_nxt;

  logic                  ls_free_nxt, ls_out_en_nxt, mem_rw_nxt;
  logic [31:0]           ldata_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [7:0]            mem_wdata_nxt;
  logic [1:0]            cap_idx;

  function automatic logic [2:0] byte_count(input logic [2:0] len);
    case (len)
      3'd0:    return 3'd1;
      3'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign cap_idx = 2'(idx - 3'd2);

  // Next state, latched request and next registered output values
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    lat_addr_nxt  = lat_addr;
    lat_rw_nxt    = lat_rw;
    lat_n_nxt     = lat_n;
    lat_sdata_nxt = lat_sdata;
    ls_free_nxt   = 1'b0;
    ls_out_en_nxt = 1'b0;
    ldata_nxt     = bus.Ldata;
    mem_addr_nxt  = '0;
    mem_rw_nxt    = 1'b0;
    mem_wdata_nxt = 8'h00;
    case (state)
      IDLE: begin
        ls_free_nxt = 1'b1;
        if (bus.dataEn) begin
          state_nxt     = XFER;
          lat_addr_nxt  = bus.dataAddr;
          lat_rw_nxt    = bus.LSRW;
          lat_n_nxt     = byte_count(bus.LSlen);
          lat_sdata_nxt = bus.Sdata;
          idx_nxt       = 3'd1;
          ls_free_nxt   = 1'b0;
          ldata_nxt     = '0;
          mem_addr_nxt  = bus.dataAddr;
          mem_rw_nxt    = bus.LSRW;
          mem_wdata_nxt = bus.LSRW ? bus.Sdata[7:0] : 8'h00;
        end
      end
      XFER: begin
        if (lat_rw) begin
          if (idx == lat_n) begin
            state_nxt     = DONE;
            ls_out_en_nxt = 1'b1;
            ls_free_nxt   = 1'b1;
          end else begin
            mem_addr_nxt  = lat_addr + ADDR_WIDTH'(idx);
            mem_rw_nxt    = 1'b1;
            mem_wdata_nxt = pick_byte(lat_sdata, idx[1:0]);
            idx_nxt       = idx + 3'd1;
          end
        end else begin
          if (idx >= 3'd2) begin
            case (cap_idx)
              2'd0:    ldata_nxt[7:0]   = bus.memRdata;
              2'd1:    ldata_nxt[15:8]  = bus.memRdata;
              2'd2:    ldata_nxt[23:16] = bus.memRdata;
              default: ldata_nxt[31:24] = bus.memRdata;
            endcase
          end
          if (idx == 3'(lat_n + 3'd1)) begin
            state_nxt     = DONE;
            ls_out_en_nxt = 1'b1;
            ls_free_nxt   = 1'b1;
          end else begin
            if (idx < lat_n) mem_addr_nxt = lat_addr + ADDR_WIDTH'(idx);
            idx_nxt = idx + 3'd1;
          end
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        ls_free_nxt = 1'b1;
        ldata_nxt   = '0;
      end
      default: begin
        state_nxt   = IDLE;
        ls_free_nxt = 1'b1;
      end
    endcase
  end

  // State, latched request and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      lat_addr     <= '0;
      lat_rw       <= 1'b0;
      lat_n        <= '0;
      lat_sdata    <= '0;
      bus.LSfree   <= 1'b1;
      bus.LSoutEn  <= 1'b0;
      bus.Ldata    <= '0;
      bus.memAddr  <= '0;
      bus.memRW    <= 1'b0;
      bus.memWdata <= 8'h00;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      lat_addr     <= lat_addr_nxt;
      lat_rw       <= lat_rw_nxt;
      lat_n        <= lat_n_nxt;
      lat_sdata    <= lat_sdata_nxt;
      bus.LSfree   <= ls_free_nxt;
      bus.LSoutEn  <= ls_out_en_nxt;
      bus.Ldata    <= ldata_nxt;
      bus.memAddr  <= mem_addr_nxt;
      bus.memRW    <= mem_rw_nxt;
      bus.memWdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter ADDR_WIDTH SHALL default to 32 and set the width of dataAddr and memAddr.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst, input, 1: synchronous reset, active-high.
REQ-005 Port dataEn, input, 1: the LS unit requests an access this cycle.
REQ-006 Port LSRW, input, 1: access direction; 0 = read, 1 = write.
REQ-007 Port dataAddr, input, ADDR_WIDTH: byte address of the first byte.
REQ-008 Port LSlen, input, 3: access size as byte count minus one; 0 = byte, 1 = half, 3 = word.
REQ-009 Port Sdata, input, 32: store data, little-endian; byte k is Sdata[8k+7:8k].
REQ-010 Port LSoutEn, output, 1: one-cycle pulse that signals the access has completed.
REQ-011 Port Ldata, output, 32: assembled load data, valid only while LSoutEn=1.
REQ-012 Port LSfree, output, 1: the block is ready to accept dataEn.
REQ-013 Port memAddr, output, ADDR_WIDTH: byte address to the single-port byte RAM.
REQ-014 Port memRW, output, 1: RAM write strobe; 1 = write this cycle.
REQ-015 Port memWdata, output, 8: RAM write byte.
REQ-016 Port memRdata, input, 8: RAM read byte; it returns data for the memAddr presented in the previous cycle.

Function
REQ-017 The state machine SHALL have three states: IDLE, XFER and DONE.
REQ-018 All outputs SHALL be registered.
REQ-019 Byte count N SHALL be computed as follows.
- LSlen=0 → N=1.
- LSlen=1 → N=2.
- Any other LSlen value → N=4.
REQ-020 In IDLE, LSfree SHALL be 1, and memAddr, memRW and memWdata SHALL all be 0.
REQ-021 When dataEn=1 is sampled in IDLE, the block SHALL latch dataAddr, LSRW, N and Sdata, and enter XFER.
REQ-022 During XFER, LSfree SHALL be 0.
REQ-023 Byte k (k = 0..N-1) SHALL be presented in the k-th XFER cycle.
- memAddr = latched address + k, truncated to ADDR_WIDTH, so the address wraps from all-ones to 0.
REQ-024 For a write, each XFER cycle SHALL drive memRW=1 and memWdata = latched Sdata byte k.
REQ-025 For a write, after byte N-1 the block SHALL enter DONE.
REQ-026 For a read, each XFER cycle SHALL drive memRW=0.
REQ-027 For a read, memRdata SHALL be captured one cycle after each address, into Ldata[8k+7:8k].
REQ-028 For a read, the block SHALL enter DONE once byte N-1 has been captured.
- This takes one extra XFER cycle with memAddr=0 and memRW=0.
REQ-029 In DONE, the block SHALL do all of the following for exactly one cycle, then return to IDLE:
- LSoutEn=1.
- LSfree=1.
- memRW=0 and memAddr=0.
REQ-030 Ldata bytes at or above N SHALL be 0; extension is not this block's job.
REQ-031 Ldata SHALL be 0 after a write.
REQ-032 Latency from the dataEn sample edge to the LSoutEn cycle SHALL be:
- write: N+1 cycles;
- read: N+2 cycles.
REQ-033 dataEn sampled in XFER or DONE SHALL be ignored, with no state or output change.
REQ-034 dataEn sampled in the first IDLE cycle after DONE SHALL be accepted, so back-to-back accesses are supported.
REQ-035 memRW SHALL never be 1 outside XFER.
REQ-036 At most one memory transaction SHALL be in flight at any time.

Reset
REQ-037 When rst=1 is sampled, the state SHALL become IDLE and the outputs SHALL take these values:
- LSfree=1;
- LSoutEn=0;
- Ldata=0;
- memAddr=0, memRW=0, memWdata=0.
REQ-038 A reset during XFER or DONE SHALL abort the access: no further RAM writes, and no LSoutEn pulse.
REQ-039 rst=1 together with dataEn=1 SHALL give reset priority; the request is dropped.

Verification
REQ-040 Word store: dataEn, LSRW=1, dataAddr=0x100, LSlen=3, Sdata=0xA1B2C3D4.
- Expect 4 consecutive writes: 0x100←D4, 0x101←C3, 0x102←B2, 0x103←A1.
- Expect LSoutEn in cycle 5 with Ldata=0.
REQ-041 Word load after REQ-040: LSRW=0, dataAddr=0x100, LSlen=3.
- Expect LSoutEn in cycle 6 with Ldata=0xA1B2C3D4.
- Expect LSfree=0 during cycles 1-5.
REQ-042 Byte and half loads from a RAM preloaded 0x200=0x80, 0x201=0xFF:
- LSlen=0 at 0x200 → Ldata=0x00000080;
- LSlen=1 at 0x200 → Ldata=0x0000FF80.
REQ-043 Wrap: half store, dataAddr=0xFFFFFFFF, Sdata=0x1234.
- Expect writes 0xFFFFFFFF←34 and 0x00000000←12.
REQ-044 Reset in the second XFER cycle of a word store:
- only byte 0 is written;
- no LSoutEn;
- outputs hold reset values;
- a new load issued afterwards completes normally.
REQ-045 Back-to-back and busy requests:
- dataEn held high continuously → accesses are accepted only in IDLE, each producing exactly one LSoutEn pulse;
- dataEn pulsed during XFER → ignored.
